// File: rtl/tdc_interval_capture.sv
// TDC interval capture: arms on request, latches start/stop fine bins around a
// coarse cycle counter and presents one signed interval over valid/ready.
module tdc_interval_capture #(
  parameter int unsigned BITS_DECO    = 8,
  parameter int unsigned BITS_COARSE  = 16,
  parameter int unsigned BINS_PER_CLK = 200,
  parameter int unsigned MAX_COARSE   = 1000
) (
  input  logic                                  wClk,
  input  logic                                  wRst,
  input  logic                                  wArm,
  input  logic [BITS_DECO-1:0]                  wStartBin,
  input  logic [BITS_DECO-1:0]                  wStopBin,
  output logic                                  wValid,
  input  logic                                  wReady,
  output logic                                  wBusy,
  output logic                                  wTimeout,
  output logic [BITS_COARSE-1:0]                wCoarse,
  output logic [BITS_DECO-1:0]                  wStartBinOut,
  output logic [BITS_DECO-1:0]                  wStopBinOut,
  output logic signed [BITS_COARSE+BITS_DECO+1:0] wInterval
);

  localparam int unsigned W_INT = BITS_COARSE + BITS_DECO + 2;
  localparam logic [BITS_COARSE-1:0]  C_MAX  = BITS_COARSE'(MAX_COARSE);
  localparam logic signed [W_INT-1:0] C_BINS = W_INT'(BINS_PER_CLK);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_RUNNING,
    S_DONE
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;

  logic [BITS_COARSE-1:0]   r_count;
  logic [BITS_COARSE-1:0]   w_count_nxt;
  logic [BITS_COARSE-1:0]   w_count_inc;
  logic [BITS_DECO-1:0]     r_start_lat;
  logic [BITS_DECO-1:0]     w_start_lat_nxt;

  logic                     r_valid;
  logic                     r_busy;
  logic                     r_timeout;
  logic [BITS_COARSE-1:0]   r_coarse;
  logic [BITS_DECO-1:0]     r_start_out;
  logic [BITS_DECO-1:0]     r_stop_out;
  logic signed [W_INT-1:0]  r_interval;

  logic                     w_start_seen;
  logic                     w_stop_seen;
  logic                     w_load;
  logic                     w_fin_timeout;
  logic [BITS_COARSE-1:0]   w_fin_coarse;
  logic [BITS_DECO-1:0]     w_fin_start;
  logic [BITS_DECO-1:0]     w_fin_stop;
  logic signed [W_INT-1:0]  w_interval_calc;

  assign w_start_seen = |wStartBin;
  assign w_stop_seen  = |wStopBin;
  assign w_count_inc  = r_count + 1'b1;

  // Operands are zero-extended into the full interval width before the signed
  // arithmetic, so only the final subtraction can produce a negative result.
  assign w_interval_calc = $signed(W_INT'(w_fin_coarse)) * C_BINS
                         + $signed(W_INT'(w_fin_start))
                         - $signed(W_INT'(w_fin_stop));

  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_start_lat_nxt = r_start_lat;
    w_load          = 1'b0;
    w_fin_timeout   = 1'b0;
    w_fin_coarse    = '0;
    w_fin_start     = r_start_lat;
    w_fin_stop      = '0;

    unique case (r_state)
      S_IDLE: begin
        if (wArm) w_state_nxt = S_ARMED;
      end

      S_ARMED: begin
        if (w_start_seen) begin
          w_start_lat_nxt = wStartBin;
          w_count_nxt     = '0;
          if (w_stop_seen) begin
            w_load       = 1'b1;
            w_fin_coarse = '0;
            w_fin_start  = wStartBin;
            w_fin_stop   = wStopBin;
            w_state_nxt  = S_DONE;
          end else begin
            w_state_nxt  = S_RUNNING;
          end
        end
      end

      S_RUNNING: begin
        w_count_nxt = w_count_inc;
        // A stop on the final cycle wins over the timeout.
        if (w_stop_seen) begin
          w_load       = 1'b1;
          w_fin_coarse = w_count_inc;
          w_fin_stop   = wStopBin;
          w_state_nxt  = S_DONE;
        end else if (w_count_inc == C_MAX) begin
          w_load        = 1'b1;
          w_fin_timeout = 1'b1;
          w_fin_coarse  = C_MAX;
          w_fin_stop    = '0;
          w_state_nxt   = S_DONE;
        end
      end

      S_DONE: begin
        if (r_valid && wReady) w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wClk or posedge wRst) begin
    if (wRst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge wClk or posedge wRst) begin
    if (wRst) begin
      r_count     <= '0;
      r_start_lat <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
      r_coarse    <= '0;
      r_start_out <= '0;
      r_stop_out  <= '0;
      r_interval  <= '0;
    end else begin
      r_count     <= w_count_nxt;
      r_start_lat <= w_start_lat_nxt;
      r_valid     <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt != S_IDLE);
      // Result registers only move on entry to DONE, so they hold while valid.
      if (w_load) begin
        r_timeout   <= w_fin_timeout;
        r_coarse    <= w_fin_coarse;
        r_start_out <= w_fin_start;
        r_stop_out  <= w_fin_stop;
        r_interval  <= w_interval_calc;
      end
    end
  end

  assign wValid       = r_valid;
  assign wBusy        = r_busy;
  assign wTimeout     = r_timeout;
  assign wCoarse      = r_coarse;
  assign wStartBinOut = r_start_out;
  assign wStopBinOut  = r_stop_out;
  assign wInterval    = r_interval;

endmodule

// File: tb/tb_tdc_interval_capture.sv
// Directed bench for tdc_interval_capture with a scoreboard of expected results.
module tb_tdc_interval_capture;

  localparam int unsigned BITS_DECO    = 8;
  localparam int unsigned BITS_COARSE  = 16;
  localparam int unsigned BINS_PER_CLK = 200;
  localparam int unsigned MAX_COARSE   = 1000;
  localparam int unsigned W_INT        = BITS_COARSE + BITS_DECO + 2;

  logic                        wClk = 1'b0;
  logic                        wRst;
  logic                        wArm;
  logic [BITS_DECO-1:0]        wStartBin;
  logic [BITS_DECO-1:0]        wStopBin;
  logic                        wValid;
  logic                        wReady;
  logic                        wBusy;
  logic                        wTimeout;
  logic [BITS_COARSE-1:0]      wCoarse;
  logic [BITS_DECO-1:0]        wStartBinOut;
  logic [BITS_DECO-1:0]        wStopBinOut;
  logic signed [W_INT-1:0]     wInterval;

  tdc_interval_capture #(
    .BITS_DECO   (BITS_DECO),
    .BITS_COARSE (BITS_COARSE),
    .BINS_PER_CLK(BINS_PER_CLK),
    .MAX_COARSE  (MAX_COARSE)
  ) dut (
    .wClk        (wClk),
    .wRst        (wRst),
    .wArm        (wArm),
    .wStartBin   (wStartBin),
    .wStopBin    (wStopBin),
    .wValid      (wValid),
    .wReady      (wReady),
    .wBusy       (wBusy),
    .wTimeout    (wTimeout),
    .wCoarse     (wCoarse),
    .wStartBinOut(wStartBinOut),
    .wStopBinOut (wStopBinOut),
    .wInterval   (wInterval)
  );

  always #5 wClk = ~wClk;

  typedef struct {
    bit     timeout;
    longint coarse;
    longint start;
    longint stop;
    longint interval;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wClk);
    #1;
  endtask

  task automatic push_exp(input bit t, input longint c, input longint s, input longint p);
    exp_t e;
    e.timeout  = t;
    e.coarse   = c;
    e.start    = s;
    e.stop     = p;
    e.interval = c * BINS_PER_CLK + s - p;
    sb.push_back(e);
  endtask

  task automatic chk_outputs(input exp_t e, input string tag);
    chk({tag, "_valid"},    longint'(wValid),       1);
    chk({tag, "_timeout"},  longint'(wTimeout),     longint'(e.timeout));
    chk({tag, "_coarse"},   longint'(wCoarse),      e.coarse);
    chk({tag, "_start"},    longint'(wStartBinOut), e.start);
    chk({tag, "_stop"},     longint'(wStopBinOut),  e.stop);
    chk({tag, "_interval"}, longint'(wInterval),    e.interval);
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk_outputs(e, tag);
    end
  endtask

  task automatic wait_valid(input int max_cyc, input string tag, output int n);
    n = 0;
    while (!wValid && n < max_cyc) begin
      step();
      n++;
    end
    chk({tag, "_wait_valid"}, longint'(wValid), 1);
  endtask

  task automatic handshake(input string tag);
    wReady = 1'b1;
    step();
    wReady = 1'b0;
    chk({tag, "_valid_drop"}, longint'(wValid), 0);
    chk({tag, "_idle"},       longint'(wBusy),  0);
  endtask

  task automatic arm();
    wArm = 1'b1;
    step();
    wArm = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},    longint'(wValid),       0);
    chk({tag, "_busy"},     longint'(wBusy),        0);
    chk({tag, "_timeout"},  longint'(wTimeout),     0);
    chk({tag, "_coarse"},   longint'(wCoarse),      0);
    chk({tag, "_start"},    longint'(wStartBinOut), 0);
    chk({tag, "_stop"},     longint'(wStopBinOut),  0);
    chk({tag, "_interval"}, longint'(wInterval),    0);
  endtask

  initial begin
    int n;
    wRst = 1'b1; wArm = 1'b0; wStartBin = '0; wStopBin = '0; wReady = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
    wRst = 1'b0;
    step();

    // Start 37, stop 12 five cycles later
    arm();
    chk("t1_busy_armed", longint'(wBusy), 1);
    wStartBin = 8'd37;
    step();
    wStartBin = '0;
    chk("t1_no_valid_run", longint'(wValid), 0);
    repeat (4) step();
    wStopBin = 8'd12;
    push_exp(0, 5, 37, 12);
    step();
    wStopBin = '0;
    chk("t1_latency", longint'(wValid), 1);
    check_result("t1");
    handshake("t1");

    // Start and stop in the same cycle: negative interval
    arm();
    wStartBin = 8'd50; wStopBin = 8'd80;
    push_exp(0, 0, 50, 80);
    step();
    wStartBin = '0; wStopBin = '0;
    chk("t2_latency", longint'(wValid), 1);
    check_result("t2");
    handshake("t2");

    // Stop before start is ignored
    arm();
    wStopBin = 8'd20;
    step();
    wStopBin = '0;
    chk("t5_stay_armed_busy", longint'(wBusy), 1);
    chk("t5_no_valid", longint'(wValid), 0);
    repeat (2) step();
    wStartBin = 8'd100;
    step();
    wStartBin = '0;
    repeat (2) step();
    wStopBin = 8'd150;
    push_exp(0, 3, 100, 150);
    step();
    wStopBin = '0;
    chk("t5_latency", longint'(wValid), 1);

    // Hold the result with ready low while inputs toggle
    for (int i = 0; i < 20; i++) begin
      wArm      = 1'($urandom_range(0, 1));
      wStartBin = 8'($urandom_range(0, 255));
      wStopBin  = 8'($urandom_range(0, 255));
      step();
      if (sb.size() > 0) chk_outputs(sb[0], "t4_frozen");
      else chk("t4_sb_nonempty", 0, 1);
    end
    wStartBin = '0; wStopBin = '0;
    wArm = 1'b1;
    wReady = 1'b1;
    step();
    wReady = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
    chk("t4_valid_drop", longint'(wValid), 0);
    chk("t4_no_rearm_handover", longint'(wBusy), 0);
    step();
    wArm = 1'b0;
    chk("t4_rearm_from_idle", longint'(wBusy), 1);

    // Timeout: start with no stop
    wStartBin = 8'd10;
    push_exp(1, MAX_COARSE, 10, 0);
    step();
    wStartBin = '0;
    wait_valid(MAX_COARSE + 100, "t3", n);
    chk("t3_cycles", longint'(n), MAX_COARSE);
    check_result("t3");
    handshake("t3");

    // Reset while running, then a clean measurement
    arm();
    wStartBin = 8'd7;
    step();
    wStartBin = '0;
    repeat (300) step();
    chk("t6_busy_running", longint'(wBusy), 1);
    #2 wRst = 1'b1;
    #1;
    chk_all_zero("t6_reset");
    step();
    wRst = 1'b0;
    step();
    chk_all_zero("t6_after_reset");
    arm();
    wStartBin = 8'd200;
    step();
    wStartBin = '0;
    wStopBin = 8'd1;
    push_exp(0, 1, 200, 1);
    step();
    wStopBin = '0;
    chk("t6_latency", longint'(wValid), 1);
    check_result("t6");
    handshake("t6");

    chk("sb_drained", longint'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
